// File: rtl/pipeline_pkg.sv
// Shared opcode, field and scoreboard definitions for the 20-bit 5-stage pipeline.
package pipeline_pkg;

    localparam int unsigned INSTR_W = 20;
    localparam int unsigned OP_W    = 4;
    localparam int unsigned REG_W   = 4;

    localparam int unsigned OP_MSB = 19;
    localparam int unsigned OP_LSB = 16;
    localparam int unsigned A_MSB  = 15;
    localparam int unsigned A_LSB  = 12;
    localparam int unsigned B_MSB  = 11;
    localparam int unsigned B_LSB  = 8;
    localparam int unsigned C_MSB  = 7;
    localparam int unsigned C_LSB  = 4;

    localparam logic [OP_W-1:0] OP_NOP   = 4'b0000;
    localparam logic [OP_W-1:0] OP_STORE = 4'b1100;
    localparam logic [OP_W-1:0] OP_BEQ   = 4'b1101;
    localparam logic [OP_W-1:0] OP_HALT  = 4'b1111;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_STALL,
        ST_FLUSH,
        ST_MEM_WAIT,
        ST_DRAIN,
        ST_HALTED
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] waddr;
    } sb_entry_t;

    // True when a read of addr must wait for one of the in-flight writers.
    function automatic logic in_flight(input sb_entry_t ex, input sb_entry_t mem,
                                       input sb_entry_t wb, input logic [REG_W-1:0] addr);
        return (ex.valid  && (ex.waddr  == addr)) ||
               (mem.valid && (mem.waddr == addr)) ||
               (wb.valid  && (wb.waddr  == addr));
    endfunction

endpackage

// File: rtl/hazard_operand_decode.sv
// Classifies an instruction into its register reads and write; shared with decode.
module hazard_operand_decode
    import pipeline_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_i,
    output logic               rs0_en_c,
    output logic [REG_W-1:0]   rs0_addr_c,
    output logic               rs1_en_c,
    output logic [REG_W-1:0]   rs1_addr_c,
    output logic               wr_en_c,
    output logic [REG_W-1:0]   wr_addr_c,
    output logic               is_halt_c
);

    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] fa;
    logic [REG_W-1:0] fb;
    logic [REG_W-1:0] fc;
    logic             unused_low;

    assign op         = instr_i[OP_MSB:OP_LSB];
    assign fa         = instr_i[A_MSB:A_LSB];
    assign fb         = instr_i[B_MSB:B_LSB];
    assign fc         = instr_i[C_MSB:C_LSB];
    assign unused_low = ^instr_i[C_LSB-1:0];

    always_comb begin
        rs0_en_c   = 1'b0;
        rs0_addr_c = fb;
        rs1_en_c   = 1'b0;
        rs1_addr_c = fc;
        wr_en_c    = 1'b0;
        wr_addr_c  = fa;
        is_halt_c  = 1'b0;
        case (op)
            OP_NOP: ;
            OP_HALT: is_halt_c = 1'b1;
            // Stores and compares read A and B and write nothing.
            OP_STORE, OP_BEQ: begin
                rs0_en_c   = 1'b1;
                rs0_addr_c = fa;
                rs1_en_c   = 1'b1;
                rs1_addr_c = fb;
            end
            default: begin
                rs0_en_c = 1'b1;
                rs1_en_c = 1'b1;
                wr_en_c  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Owns PC and pipeline-register controls: RAW stalls via a 3-entry destination
// scoreboard, memory-wait freeze, branch flush and HALT drain.
module pipeline_hazard_controller
    import pipeline_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [INSTR_W-1:0] id_instruction,
    input  logic               branch_taken,
    input  logic               mem_busy,
    output logic               pc_enable,
    output logic               ifid_enable,
    output logic               ifid_flush,
    output logic               idex_bubble,
    output logic               pipe_freeze,
    output logic               halted
);

    state_e    state_q, state_d;
    sb_entry_t ex_q, ex_d;
    sb_entry_t mem_q, mem_d;
    sb_entry_t wb_q, wb_d;

    logic             rs0_en, rs1_en, wr_en, is_halt;
    logic [REG_W-1:0] rs0_addr, rs1_addr, wr_addr;
    logic             hazard;
    logic             sb_empty;

    hazard_operand_decode u_decode (
        .instr_i    (id_instruction),
        .rs0_en_c   (rs0_en),
        .rs0_addr_c (rs0_addr),
        .rs1_en_c   (rs1_en),
        .rs1_addr_c (rs1_addr),
        .wr_en_c    (wr_en),
        .wr_addr_c  (wr_addr),
        .is_halt_c  (is_halt)
    );

    assign hazard = id_valid &&
                    ((rs0_en && in_flight(ex_q, mem_q, wb_q, rs0_addr)) ||
                     (rs1_en && in_flight(ex_q, mem_q, wb_q, rs1_addr)));
    assign sb_empty = !ex_q.valid && !mem_q.valid && !wb_q.valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ex_d        = '0;
        mem_d       = ex_q;
        wb_d        = mem_q;
        pc_enable   = 1'b1;
        ifid_enable = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        halted      = 1'b0;

        if (state_q == ST_HALTED) begin
            pc_enable   = 1'b0;
            ifid_enable = 1'b0;
            idex_bubble = 1'b1;
            halted      = 1'b1;
        end else if (mem_busy) begin
            // Whole pipe holds, scoreboard included; a drain resumes where it left off.
            pc_enable   = 1'b0;
            ifid_enable = 1'b0;
            pipe_freeze = 1'b1;
            ex_d        = ex_q;
            mem_d       = mem_q;
            wb_d        = wb_q;
            if (state_q != ST_DRAIN) begin
                state_d = ST_MEM_WAIT;
            end
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = ST_FLUSH;
        end else if (state_q == ST_DRAIN) begin
            pc_enable   = 1'b0;
            ifid_enable = 1'b0;
            idex_bubble = 1'b1;
            if (sb_empty) begin
                state_d = ST_HALTED;
            end
        end else if (hazard) begin
            pc_enable   = 1'b0;
            ifid_enable = 1'b0;
            idex_bubble = 1'b1;
            state_d     = ST_STALL;
        end else if (id_valid && is_halt) begin
            pc_enable   = 1'b0;
            ifid_enable = 1'b0;
            idex_bubble = 1'b1;
            state_d     = ST_DRAIN;
        end else begin
            ex_d.valid = id_valid && wr_en;
            ex_d.waddr = wr_addr;
            state_d    = ST_RUN;
        end

        if (!reset) begin
            pc_enable   = 1'b0;
            ifid_enable = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
            pipe_freeze = 1'b0;
            halted      = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed scoreboard bench for pipeline_hazard_controller; outputs are compared as
// the vector {pc_enable, ifid_enable, ifid_flush, idex_bubble, pipe_freeze, halted}.
module tb_pipeline_hazard_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [19:0] id_instruction;
    logic        branch_taken;
    logic        mem_busy;
    logic        pc_enable, ifid_enable, ifid_flush, idex_bubble, pipe_freeze, halted;

    int total = 0;
    int bad   = 0;

    string      tagq[$];
    logic [5:0] expq[$];
    logic [5:0] obs;

    localparam logic [5:0] ISSUE  = 6'b110000;
    localparam logic [5:0] STALL  = 6'b000100;
    localparam logic [5:0] FREEZE = 6'b000010;
    localparam logic [5:0] BRANCH = 6'b111100;
    localparam logic [5:0] HALTO  = 6'b000101;
    localparam logic [5:0] RESETO = 6'b000100;

    pipeline_hazard_controller dut (
        .clock          (clock),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_instruction (id_instruction),
        .branch_taken   (branch_taken),
        .mem_busy       (mem_busy),
        .pc_enable      (pc_enable),
        .ifid_enable    (ifid_enable),
        .ifid_flush     (ifid_flush),
        .idex_bubble    (idex_bubble),
        .pipe_freeze    (pipe_freeze),
        .halted         (halted)
    );

    always #5 clock = ~clock;

    assign obs = {pc_enable, ifid_enable, ifid_flush, idex_bubble, pipe_freeze, halted};

    function automatic logic [19:0] mk(input logic [3:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c, 4'h0};
    endfunction

    task automatic check_head();
        string      t;
        logic [5:0] e;
        t = tagq.pop_front();
        e = expq.pop_front();
        total++;
        assert (obs === e) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", t, obs, e);
        end
    endtask

    // Drive one ID-stage cycle, check at the falling edge, advance past the rising edge.
    task automatic step(input string tag, input logic [19:0] ins, input logic br,
                        input logic mb, input logic [5:0] exp);
        id_valid       = 1'b1;
        id_instruction = ins;
        branch_taken   = br;
        mem_busy       = mb;
        tagq.push_back(tag);
        expq.push_back(exp);
        @(negedge clock);
        check_head();
        @(posedge clock);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step("nop", mk(4'h0, 4'h0, 4'h0, 4'h0), 1'b0, 1'b0, ISSUE);
    endtask

    // Assert reset off-edge, check immediately and at the next falling edge, then release.
    task automatic pulse_reset(input string tag);
        reset = 1'b0;
        #1;
        tagq.push_back({tag, "_async"});
        expq.push_back(RESETO);
        check_head();
        tagq.push_back({tag, "_hold"});
        expq.push_back(RESETO);
        @(negedge clock);
        check_head();
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset          = 1'b0;
        id_valid       = 1'b0;
        id_instruction = '0;
        branch_taken   = 1'b0;
        mem_busy       = 1'b0;
        tagq.push_back("reset_values");
        expq.push_back(RESETO);
        @(negedge clock);
        check_head();
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Back-to-back dependency: three bubbles.
        step("b2b_prod", mk(4'h1, 4'd3, 4'd1, 4'd2), 1'b0, 1'b0, ISSUE);
        for (int i = 0; i < 3; i++) step("b2b_stall", mk(4'h1, 4'd4, 4'd3, 4'd5), 1'b0, 1'b0, STALL);
        step("b2b_issue", mk(4'h1, 4'd4, 4'd3, 4'd5), 1'b0, 1'b0, ISSUE);
        nops(3);

        // Distance 2: two bubbles.
        step("d2_prod", mk(4'h1, 4'd5, 4'd0, 4'd0), 1'b0, 1'b0, ISSUE);
        nops(1);
        for (int i = 0; i < 2; i++) step("d2_stall", mk(4'h1, 4'd6, 4'd5, 4'd5), 1'b0, 1'b0, STALL);
        step("d2_issue", mk(4'h1, 4'd6, 4'd5, 4'd5), 1'b0, 1'b0, ISSUE);

        // Distance 3: one bubble.
        step("d3_prod", mk(4'h1, 4'd7, 4'd0, 4'd0), 1'b0, 1'b0, ISSUE);
        nops(2);
        step("d3_stall", mk(4'h1, 4'd8, 4'd7, 4'd9), 1'b0, 1'b0, STALL);
        step("d3_issue", mk(4'h1, 4'd8, 4'd7, 4'd9), 1'b0, 1'b0, ISSUE);

        // Distance 4: no bubble.
        step("d4_prod", mk(4'h1, 4'd9, 4'd0, 4'd0), 1'b0, 1'b0, ISSUE);
        nops(3);
        step("d4_issue", mk(4'h1, 4'd10, 4'd9, 4'd8), 1'b0, 1'b0, ISSUE);
        nops(3);

        // STORE reads field A; STORE writes nothing; BEQ reads field A.
        step("st_prod", mk(4'h1, 4'd7, 4'd8, 4'd9), 1'b0, 1'b0, ISSUE);
        for (int i = 0; i < 3; i++) step("st_stall_a", mk(4'hC, 4'd7, 4'd10, 4'd0), 1'b0, 1'b0, STALL);
        step("st_issue", mk(4'hC, 4'd7, 4'd10, 4'd0), 1'b0, 1'b0, ISSUE);
        step("st_nowrite", mk(4'h1, 4'd1, 4'd7, 4'd7), 1'b0, 1'b0, ISSUE);
        for (int i = 0; i < 3; i++) step("beq_stall_a", mk(4'hD, 4'd1, 4'd0, 4'd0), 1'b0, 1'b0, STALL);
        step("beq_issue", mk(4'hD, 4'd1, 4'd0, 4'd0), 1'b0, 1'b0, ISSUE);
        nops(3);

        // Memory wait mid-stall: freeze 4 cycles, remaining stall count unchanged.
        step("mw_prod", mk(4'h1, 4'd2, 4'd11, 4'd11), 1'b0, 1'b0, ISSUE);
        step("mw_stall_pre", mk(4'h1, 4'd12, 4'd2, 4'd2), 1'b0, 1'b0, STALL);
        for (int i = 0; i < 4; i++) step("mw_freeze", mk(4'h1, 4'd12, 4'd2, 4'd2), 1'b0, 1'b1, FREEZE);
        for (int i = 0; i < 2; i++) step("mw_stall_post", mk(4'h1, 4'd12, 4'd2, 4'd2), 1'b0, 1'b0, STALL);
        step("mw_issue", mk(4'h1, 4'd12, 4'd2, 4'd2), 1'b0, 1'b0, ISSUE);
        nops(3);

        // Branch over a hazarding instruction; memory wait outranks the flush.
        step("br_prod", mk(4'h1, 4'd13, 4'd14, 4'd14), 1'b0, 1'b0, ISSUE);
        step("br_frozen", mk(4'h1, 4'd15, 4'd13, 4'd13), 1'b1, 1'b1, FREEZE);
        step("br_flush", mk(4'h1, 4'd15, 4'd13, 4'd13), 1'b1, 1'b0, BRANCH);
        step("br_after", mk(4'h0, 4'd0, 4'd0, 4'd0), 1'b0, 1'b0, ISSUE);
        nops(3);

        // HALT after two writers: issue as bubble, drain 3 cycles, then halted.
        step("h_w1", mk(4'h1, 4'd1, 4'd2, 4'd3), 1'b0, 1'b0, ISSUE);
        step("h_w2", mk(4'h1, 4'd4, 4'd5, 4'd6), 1'b0, 1'b0, ISSUE);
        step("h_issue", mk(4'hF, 4'd0, 4'd0, 4'd0), 1'b0, 1'b0, STALL);
        for (int i = 0; i < 3; i++) step("h_drain", mk(4'h0, 4'd0, 4'd0, 4'd0), 1'b0, 1'b0, STALL);
        for (int i = 0; i < 2; i++) step("h_halted", mk(4'h0, 4'd0, 4'd0, 4'd0), 1'b0, 1'b0, HALTO);
        step("h_sticky", mk(4'h1, 4'd1, 4'd1, 4'd1), 1'b1, 1'b1, HALTO);

        pulse_reset("rst_halted");
        step("rst_run", mk(4'h0, 4'd0, 4'd0, 4'd0), 1'b0, 1'b0, ISSUE);

        // Reset mid-drain clears the scoreboard: a reader of r4 issues at once.
        step("rd_w1", mk(4'h1, 4'd1, 4'd2, 4'd3), 1'b0, 1'b0, ISSUE);
        step("rd_w2", mk(4'h1, 4'd4, 4'd5, 4'd6), 1'b0, 1'b0, ISSUE);
        step("rd_halt", mk(4'hF, 4'd0, 4'd0, 4'd0), 1'b0, 1'b0, STALL);
        step("rd_drain", mk(4'h0, 4'd0, 4'd0, 4'd0), 1'b0, 1'b0, STALL);
        pulse_reset("rst_drain");
        step("rd_sb_empty", mk(4'h1, 4'd9, 4'd4, 4'd4), 1'b0, 1'b0, ISSUE);
        step("rd_not_halted", mk(4'h0, 4'd0, 4'd0, 4'd0), 1'b0, 1'b0, ISSUE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
